// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-side memory controller.
// Holds the word width, the I/O address map, the controller state
// encoding and the store-entry record. The processor's memory stage
// uses the store-entry record as well.
package data_mem_ctrl_pkg;

    localparam int WORD_SIZE = 16;

    // Memory-mapped I/O locations. These are decoded before any memory access.
    localparam logic [WORD_SIZE-1:0] LED_ADDR = 16'h1000;
    localparam logic [WORD_SIZE-1:0] SW_ADDR  = 16'h3000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RD      = 2'd2,
        RD_DONE = 2'd3
    } dmcState_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
    } storeEntry_t;

endpackage

// File: rtl/data_mem_ctrl_store_buffer.sv
// Write buffer (store_buffer) for the data memory controller.
// This is a circular FIFO of store entries. It also has a lookup port
// that reports the youngest valid entry whose address matches.
// Ports:
//   Clock, Reset            clock and asynchronous active-high reset
//   i_push, i_pushEntry     enqueue a store (ignored while full)
//   i_pop                   dequeue the head (ignored while empty)
//   i_lookupAddr            address to search for among valid entries
//   o_head                  oldest entry
//   o_count                 number of valid entries
//   o_full, o_empty         occupancy flags (o_empty is registered)
//   o_match, o_matchData    lookup hit flag and data of the youngest hit
module data_mem_ctrl_store_buffer
    import data_mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 i_push,
    input  storeEntry_t          i_pushEntry,
    input  logic                 i_pop,
    input  logic [WORD_SIZE-1:0] i_lookupAddr,
    output storeEntry_t          o_head,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_match,
    output logic [WORD_SIZE-1:0] o_matchData
);

    storeEntry_t      r_entries [DEPTH];
    logic [PTR_W-1:0] r_headPtr;
    logic [PTR_W-1:0] r_tailPtr;
    logic [CNT_W-1:0] r_count;
    logic             r_empty;

    logic             w_doPush;
    logic             w_doPop;
    logic [CNT_W-1:0] w_countNext;
    logic [PTR_W-1:0] w_lookupIdx;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = r_empty;
    assign o_count  = r_count;
    assign o_head   = r_entries[r_headPtr];
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~r_empty;

    // The count is unchanged when a push and a pop happen in the same cycle.
    always_comb begin
        w_countNext = r_count;
        if (w_doPush && !w_doPop) begin
            w_countNext = r_count + 1'b1;
        end else if (!w_doPush && w_doPop) begin
            w_countNext = r_count - 1'b1;
        end
    end

    // The pointers wrap naturally because DEPTH is a power of two.
    // o_empty is taken from the next count, so it is a true register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_headPtr <= '0;
            r_tailPtr <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
        end else begin
            if (w_doPush) begin
                r_tailPtr <= r_tailPtr + 1'b1;
            end
            if (w_doPop) begin
                r_headPtr <= r_headPtr + 1'b1;
            end
            r_count <= w_countNext;
            r_empty <= (w_countNext == '0);
        end
    end

    // Storage needs no reset. The count decides which entries are valid.
    always_ff @(posedge Clock) begin
        if (w_doPush) begin
            r_entries[r_tailPtr] <= i_pushEntry;
        end
    end

    // The scan runs from oldest to youngest, so a later hit overrides an
    // earlier one and the youngest store wins.
    always_comb begin
        o_match     = 1'b0;
        o_matchData = '0;
        w_lookupIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_lookupIdx = r_headPtr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_entries[w_lookupIdx].addr == i_lookupAddr)) begin
                o_match     = 1'b1;
                o_matchData = r_entries[w_lookupIdx].data;
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller.
// It sits between the processor data port and a slow single-port memory
// that uses a req/ack handshake. Stores go into a write buffer and drain
// in the background. Loads are served from the buffer when possible and
// otherwise from memory. The LED register and the switch input are
// memory-mapped.
// Ports:
//   Clock, Reset                        clock and asynchronous active-high reset
//   DataAddr, DataOut                   processor address and store data
//   WriteData, ReadData                 processor store and load strobes
//   DataIn, DataWaitreq                 load data and stall to the processor
//   mem_req, mem_we, mem_addr,
//   mem_wdata                           registered memory request
//   mem_rdata, mem_ack                  memory response
//   sw_in, ledr_out                     switch input and LED register
//   buf_empty                           write buffer is empty
module data_mem_ctrl #(
    parameter int                   WORD_SIZE = data_mem_ctrl_pkg::WORD_SIZE,
    parameter int                   BUF_DEPTH = 4,
    parameter logic [WORD_SIZE-1:0] LED_ADDR  = data_mem_ctrl_pkg::LED_ADDR,
    parameter logic [WORD_SIZE-1:0] SW_ADDR   = data_mem_ctrl_pkg::SW_ADDR,
    parameter int                   IO_WIDTH  = 10
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 WriteData,
    input  logic                 ReadData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    input  logic [IO_WIDTH-1:0]  sw_in,
    output logic [IO_WIDTH-1:0]  ledr_out,
    output logic                 buf_empty
);

    import data_mem_ctrl_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    dmcState_t            r_state;
    logic [WORD_SIZE-1:0] r_retData;

    logic                 w_ledAddr;
    logic                 w_swAddr;
    logic                 w_ioAddr;
    logic                 w_isLoad;
    logic                 w_memStore;
    logic                 w_memLoad;
    logic                 w_missLoad;
    logic                 w_push;
    logic                 w_pop;
    storeEntry_t          w_pushEntry;
    storeEntry_t          w_bufHead;
    storeEntry_t          w_drainEntry;
    logic [CNT_W-1:0]     w_bufCount;
    logic                 w_bufFull;
    logic                 w_bufEmpty;
    logic                 w_bufMatch;
    logic [WORD_SIZE-1:0] w_bufMatchData;

    // A simultaneous write strobe overrides the read strobe, so the read
    // strobe counts as a load only on its own.
    assign w_ledAddr  = (DataAddr == LED_ADDR);
    assign w_swAddr   = (DataAddr == SW_ADDR);
    assign w_ioAddr   = w_ledAddr | w_swAddr;
    assign w_isLoad   = ReadData & ~WriteData;
    assign w_memStore = WriteData & ~w_ioAddr;
    assign w_memLoad  = w_isLoad & ~w_ioAddr;
    assign w_missLoad = w_memLoad & ~w_bufMatch;
    assign w_push     = w_memStore & ~w_bufFull;
    assign w_pop      = (r_state == DRAIN) & mem_ack;
    assign buf_empty  = w_bufEmpty;

    assign w_pushEntry = '{addr: DataAddr, data: DataOut};

    // When the buffer is empty and a store is arriving, the drain starts
    // from the incoming entry. That entry becomes the head at the same edge.
    assign w_drainEntry = w_bufEmpty ? w_pushEntry : w_bufHead;

    // A full buffer stalls stores. A miss load stalls until the cycle in
    // RD_DONE, when the returned word is presented.
    assign DataWaitreq = (w_memStore & w_bufFull) |
                         (w_missLoad & (r_state != RD_DONE));

    data_mem_ctrl_store_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_storeBuffer (
        .Clock        (Clock),
        .Reset        (Reset),
        .i_push       (w_push),
        .i_pushEntry  (w_pushEntry),
        .i_pop        (w_pop),
        .i_lookupAddr (DataAddr),
        .o_head       (w_bufHead),
        .o_count      (w_bufCount),
        .o_full       (w_bufFull),
        .o_empty      (w_bufEmpty),
        .o_match      (w_bufMatch),
        .o_matchData  (w_bufMatchData)
    );

    // Load data mux. I/O is decoded first, then a buffer hit, then the
    // registered memory return.
    always_comb begin
        DataIn = '0;
        if (w_isLoad) begin
            if (w_ledAddr) begin
                DataIn = {{(WORD_SIZE-IO_WIDTH){1'b0}}, ledr_out};
            end else if (w_swAddr) begin
                DataIn = {{(WORD_SIZE-IO_WIDTH){1'b0}}, sw_in};
            end else if (w_bufMatch) begin
                DataIn = w_bufMatchData;
            end else if (r_state == RD_DONE) begin
                DataIn = r_retData;
            end
        end
    end

    // The LED register takes a store to its address with zero wait.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ledr_out <= '0;
        end else if (WriteData && w_ledAddr) begin
            ledr_out <= DataOut[IO_WIDTH-1:0];
        end
    end

    // Memory sequencer. A miss load takes priority over draining, which is
    // safe because a miss means no buffered store has that address. Every
    // transaction returns to IDLE, which inserts one idle cycle between
    // memory accesses.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_retData <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_missLoad) begin
                        r_state  <= RD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= DataAddr;
                    end else if (!w_bufEmpty || w_push) begin
                        r_state   <= DRAIN;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= w_drainEntry.addr;
                        mem_wdata <= w_drainEntry.data;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        r_state <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        r_state   <= RD_DONE;
                        r_retData <= mem_rdata;
                        mem_req   <= 1'b0;
                    end
                end
                RD_DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Raising both strobes in one cycle is a processor bug.
    assert property (@(posedge Clock) disable iff (Reset) !(ReadData && WriteData));

    // The buffer's full flag must agree with its count.
    assert property (@(posedge Clock) disable iff (Reset)
                     w_bufFull == (w_bufCount == CNT_W'(BUF_DEPTH)));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl.
// Each feature has its own task with inline checks. The bench acts as the
// memory and drives mem_ack / mem_rdata by hand.
module tb_data_mem_ctrl;

    logic        Clock;
    logic        Reset;
    logic [15:0] DataAddr;
    logic [15:0] DataOut;
    logic        WriteData;
    logic        ReadData;
    logic [15:0] DataIn;
    logic        DataWaitreq;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [9:0]  sw_in;
    logic [9:0]  ledr_out;
    logic        buf_empty;

    int checkCount = 0;
    int errorCount = 0;

    data_mem_ctrl dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .DataAddr    (DataAddr),
        .DataOut     (DataOut),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .DataIn      (DataIn),
        .DataWaitreq (DataWaitreq),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .sw_in       (sw_in),
        .ledr_out    (ledr_out),
        .buf_empty   (buf_empty)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clearInputs();
        WriteData = 1'b0;
        ReadData  = 1'b0;
        mem_ack   = 1'b0;
    endtask

    // Ack every pending memory request until the buffer has drained.
    // ok reports whether draining finished within the cycle budget.
    task automatic drainBuffer(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (buf_empty && !mem_req) begin
                ok = 1'b1;
                break;
            end
            if (mem_req) mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        checkCount++; if (mem_req !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_mem_req: got %b expected 0", mem_req); end
        checkCount++; if (mem_we !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_mem_we: got %b expected 0", mem_we); end
        checkCount++; if (mem_addr !== 16'h0000) begin errorCount++; $display("[TB] FAIL rst_mem_addr: got %h expected 0000", mem_addr); end
        checkCount++; if (mem_wdata !== 16'h0000) begin errorCount++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0000", mem_wdata); end
        checkCount++; if (DataIn !== 16'h0000) begin errorCount++; $display("[TB] FAIL rst_DataIn: got %h expected 0000", DataIn); end
        checkCount++; if (DataWaitreq !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_waitreq: got %b expected 0", DataWaitreq); end
        checkCount++; if (ledr_out !== 10'h000) begin errorCount++; $display("[TB] FAIL rst_ledr: got %h expected 000", ledr_out); end
        checkCount++; if (buf_empty !== 1'b1) begin errorCount++; $display("[TB] FAIL rst_buf_empty: got %b expected 1", buf_empty); end
        @(negedge Clock);
        Reset = 1'b0;
        tick();
        tick();
        checkCount++; if (mem_req !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_idle_req: got %b expected 0", mem_req); end
    endtask

    task automatic test_single_store();
        bit ok;
        DataAddr = 16'h0040; DataOut = 16'h1234; WriteData = 1'b1;
        #1;
        checkCount++; if (DataWaitreq !== 1'b0) begin errorCount++; $display("[TB] FAIL st1_waitreq: got %b expected 0", DataWaitreq); end
        tick();
        WriteData = 1'b0;
        checkCount++; if (mem_req !== 1'b1) begin errorCount++; $display("[TB] FAIL st1_req: got %b expected 1", mem_req); end
        checkCount++; if (mem_we !== 1'b1) begin errorCount++; $display("[TB] FAIL st1_we: got %b expected 1", mem_we); end
        checkCount++; if (mem_addr !== 16'h0040) begin errorCount++; $display("[TB] FAIL st1_addr: got %h expected 0040", mem_addr); end
        checkCount++; if (mem_wdata !== 16'h1234) begin errorCount++; $display("[TB] FAIL st1_wdata: got %h expected 1234", mem_wdata); end
        checkCount++; if (buf_empty !== 1'b0) begin errorCount++; $display("[TB] FAIL st1_not_empty: got %b expected 0", buf_empty); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkCount++; if (buf_empty !== 1'b1) begin errorCount++; $display("[TB] FAIL st1_empty_after_ack: got %b expected 1", buf_empty); end
        checkCount++; if (mem_req !== 1'b0) begin errorCount++; $display("[TB] FAIL st1_req_drop: got %b expected 0", mem_req); end
        ok = 1'b1;
    endtask

    task automatic test_buffer_full();
        logic [15:0] expAddr;
        logic [15:0] expData;
        int waitCycles;
        for (int i = 0; i < 4; i++) begin
            DataAddr = 16'h0010 + 16'(i); DataOut = 16'h0100 + 16'(i); WriteData = 1'b1;
            #1;
            checkCount++; if (DataWaitreq !== 1'b0) begin errorCount++; $display("[TB] FAIL full_accept%0d: got %b expected 0", i, DataWaitreq); end
            tick();
        end
        DataAddr = 16'h0014; DataOut = 16'h0104;
        #1;
        checkCount++; if (DataWaitreq !== 1'b1) begin errorCount++; $display("[TB] FAIL full_stall0: got %b expected 1", DataWaitreq); end
        checkCount++; if (mem_addr !== 16'h0010) begin errorCount++; $display("[TB] FAIL full_drain_head: got %h expected 0010", mem_addr); end
        tick();
        #1;
        checkCount++; if (DataWaitreq !== 1'b1) begin errorCount++; $display("[TB] FAIL full_stall1: got %b expected 1", DataWaitreq); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        checkCount++; if (DataWaitreq !== 1'b0) begin errorCount++; $display("[TB] FAIL full_accept_after_ack: got %b expected 0", DataWaitreq); end
        tick();
        WriteData = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            expAddr = 16'h0010 + 16'(k);
            expData = 16'h0100 + 16'(k);
            waitCycles = 0;
            while (!mem_req && waitCycles < 10) begin
                tick();
                waitCycles++;
            end
            checkCount++; if (mem_req !== 1'b1) begin errorCount++; $display("[TB] FAIL full_drain_req%0d: got %b expected 1", k, mem_req); end
            checkCount++; if (mem_addr !== expAddr || mem_wdata !== expData) begin errorCount++; $display("[TB] FAIL full_drain_order%0d: got %h/%h expected %h/%h", k, mem_addr, mem_wdata, expAddr, expData); end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        checkCount++; if (buf_empty !== 1'b1) begin errorCount++; $display("[TB] FAIL full_final_empty: got %b expected 1", buf_empty); end
    endtask

    task automatic test_forwarding();
        bit ok;
        DataAddr = 16'h0040; DataOut = 16'hAAAA; WriteData = 1'b1;
        tick();
        DataOut = 16'hBBBB;
        #1;
        checkCount++; if (DataWaitreq !== 1'b0) begin errorCount++; $display("[TB] FAIL fwd_second_store: got %b expected 0", DataWaitreq); end
        tick();
        WriteData = 1'b0; ReadData = 1'b1;
        #1;
        checkCount++; if (DataIn !== 16'hBBBB) begin errorCount++; $display("[TB] FAIL fwd_youngest: got %h expected BBBB", DataIn); end
        checkCount++; if (DataWaitreq !== 1'b0) begin errorCount++; $display("[TB] FAIL fwd_waitreq: got %b expected 0", DataWaitreq); end
        checkCount++; if (mem_we !== 1'b1 || mem_wdata !== 16'hAAAA) begin errorCount++; $display("[TB] FAIL fwd_no_read: got we=%b wdata=%h expected we=1 wdata=AAAA", mem_we, mem_wdata); end
        tick();
        ReadData = 1'b0;
        drainBuffer(ok);
        checkCount++; if (ok !== 1'b1) begin errorCount++; $display("[TB] FAIL fwd_drain_timeout: got %b expected 1", ok); end
    endtask

    task automatic test_miss_load();
        DataAddr = 16'h0080; ReadData = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkCount++; if (DataWaitreq !== 1'b1) begin errorCount++; $display("[TB] FAIL miss_stall%0d: got %b expected 1", i, DataWaitreq); end
            if (i == 1) begin
                checkCount++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0080) begin errorCount++; $display("[TB] FAIL miss_read_req: got req=%b we=%b addr=%h expected 1/0/0080", mem_req, mem_we, mem_addr); end
            end
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 16'h5A5A;
            end
            tick();
            mem_ack = 1'b0;
        end
        #1;
        checkCount++; if (DataWaitreq !== 1'b0) begin errorCount++; $display("[TB] FAIL miss_done_waitreq: got %b expected 0", DataWaitreq); end
        checkCount++; if (DataIn !== 16'h5A5A) begin errorCount++; $display("[TB] FAIL miss_data: got %h expected 5A5A", DataIn); end
        checkCount++; if (mem_req !== 1'b0) begin errorCount++; $display("[TB] FAIL miss_req_drop: got %b expected 0", mem_req); end
        tick();
        ReadData = 1'b0;
    endtask

    task automatic test_io();
        DataAddr = 16'h1000; DataOut = 16'hFFFF; WriteData = 1'b1;
        #1;
        checkCount++; if (DataWaitreq !== 1'b0) begin errorCount++; $display("[TB] FAIL io_led_wait: got %b expected 0", DataWaitreq); end
        tick();
        WriteData = 1'b0;
        checkCount++; if (ledr_out !== 10'h3FF) begin errorCount++; $display("[TB] FAIL io_ledr: got %h expected 3ff", ledr_out); end
        checkCount++; if (mem_req !== 1'b0) begin errorCount++; $display("[TB] FAIL io_led_no_req: got %b expected 0", mem_req); end
        DataAddr = 16'h3000; sw_in = 10'h155; ReadData = 1'b1;
        #1;
        checkCount++; if (DataIn !== 16'h0155 || DataWaitreq !== 1'b0) begin errorCount++; $display("[TB] FAIL io_sw_read: got %h/%b expected 0155/0", DataIn, DataWaitreq); end
        DataAddr = 16'h1000;
        #1;
        checkCount++; if (DataIn !== 16'h03FF) begin errorCount++; $display("[TB] FAIL io_led_read: got %h expected 03ff", DataIn); end
        tick();
        ReadData = 1'b0;
        checkCount++; if (mem_req !== 1'b0) begin errorCount++; $display("[TB] FAIL io_sw_no_req: got %b expected 0", mem_req); end
        DataAddr = 16'h3000; DataOut = 16'h0077; WriteData = 1'b1;
        #1;
        checkCount++; if (DataWaitreq !== 1'b0) begin errorCount++; $display("[TB] FAIL io_sw_write_wait: got %b expected 0", DataWaitreq); end
        tick();
        WriteData = 1'b0;
        checkCount++; if (buf_empty !== 1'b1 || mem_req !== 1'b0 || ledr_out !== 10'h3FF) begin errorCount++; $display("[TB] FAIL io_sw_write_dropped: got empty=%b req=%b ledr=%h expected 1/0/3ff", buf_empty, mem_req, ledr_out); end
    endtask

    task automatic test_reset_during_read();
        DataAddr = 16'h0020; DataOut = 16'h2000; WriteData = 1'b1;
        tick();
        DataAddr = 16'h0021; DataOut = 16'h2001;
        tick();
        DataAddr = 16'h0022; DataOut = 16'h2002; mem_ack = 1'b1;
        tick();
        clearInputs();
        DataAddr = 16'h0090; ReadData = 1'b1;
        #1;
        checkCount++; if (DataWaitreq !== 1'b1) begin errorCount++; $display("[TB] FAIL rrd_miss_stall: got %b expected 1", DataWaitreq); end
        tick();
        checkCount++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || buf_empty !== 1'b0) begin errorCount++; $display("[TB] FAIL rrd_in_read: got req=%b we=%b empty=%b expected 1/0/0", mem_req, mem_we, buf_empty); end
        ReadData = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        checkCount++; if (mem_req !== 1'b0) begin errorCount++; $display("[TB] FAIL rrd_req_cleared: got %b expected 0", mem_req); end
        checkCount++; if (buf_empty !== 1'b1) begin errorCount++; $display("[TB] FAIL rrd_buf_flushed: got %b expected 1", buf_empty); end
        checkCount++; if (ledr_out !== 10'h000) begin errorCount++; $display("[TB] FAIL rrd_ledr_cleared: got %h expected 000", ledr_out); end
        #2;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkCount++; if (mem_req !== 1'b0 || buf_empty !== 1'b1) begin errorCount++; $display("[TB] FAIL rrd_no_drain%0d: got req=%b empty=%b expected 0/1", i, mem_req, buf_empty); end
        end
    endtask

    initial begin
        Reset     = 1'b1;
        DataAddr  = '0;
        DataOut   = '0;
        WriteData = 1'b0;
        ReadData  = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        sw_in     = '0;
        #12;
        $display("[TB] test_reset");
        test_reset();
        $display("[TB] test_single_store");
        test_single_store();
        $display("[TB] test_buffer_full");
        test_buffer_full();
        $display("[TB] test_forwarding");
        test_forwarding();
        $display("[TB] test_miss_load");
        test_miss_load();
        $display("[TB] test_io");
        test_io();
        $display("[TB] test_reset_during_read");
        test_reset_during_read();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
